// File: rtl/sw_led_pkg.sv
// Shared constants, mode encoding and the Gray helper for the switch-to-LED bring-up block.
package sw_led_pkg;

  localparam int unsigned SW_W                = 7;
  localparam int unsigned MODE_BIT            = 6;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic {
    MODE_PASS = 1'b0,
    MODE_GRAY = 1'b1
  } mode_e;

  // Binary-reflected Gray code of a 6-bit value.
  function automatic logic [5:0] gray6(input logic [5:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/sw_led_if.sv
// Switch/LED pin bundle. The board (or bench) side drives switches; the block drives LEDs.
interface sw_led_if;
  import sw_led_pkg::*;

  logic [SW_W-1:0] sw_i;
  logic [SW_W-1:0] led_o;

  modport master (output sw_i, input led_o);
  modport slave  (input sw_i, output led_o);

endinterface

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchronizer, optionally followed by a stability counter.
// Build option: define SW_LED_DEBOUNCE_EN to insert the debounce counter.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  // Reject configurations the counter cannot represent.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
    $error("sw_debounce: DEBOUNCE_CYCLES must be in 2..65535");
  end

  logic [1:0] sync_q, sync_d;
  logic       s_sync;

  // Shift the raw level through the two synchronizer stages.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign s_sync = sync_q[1];

`ifdef SW_LED_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            acc_q, acc_d;

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    cnt_d = '0;
    acc_d = acc_q;
    if (s_sync != acc_q) begin
      if (cnt_q == CntMax) acc_d = s_sync;
      else                 cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state; reset discards any partial count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign q_o = acc_q;
`else
  assign q_o = s_sync;
`endif

endmodule

// File: rtl/sw_led_test.sv
// Switch-to-LED bring-up top: per-bit conditioning, mode decode and registered LED drive.
// Build option: SW_LED_DEBOUNCE_EN enables per-bit debounce (DEBOUNCE_CYCLES ignored otherwise).
module sw_led_test
  import sw_led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic     clk_i,
  input  logic     rstn_i,
  sw_led_if.slave  bus
);

  logic [SW_W-1:0] s;
  logic [SW_W-1:0] led_q, led_d;
  mode_e           mode;

  for (genvar i = 0; i < SW_W; i++) begin : g_bit
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .d_i   (bus.sw_i[i]),
      .q_o   (s[i])
    );
  end

  // Display function selected by the top switch.
  always_comb begin
    led_d = '0;
    mode  = mode_e'(s[MODE_BIT]);
    unique case (mode)
      MODE_PASS: led_d = {^s[MODE_BIT-1:0], s[MODE_BIT-1:0]};
      MODE_GRAY: led_d = {1'b1, gray6(s[MODE_BIT-1:0])};
      default:   led_d = '0;
    endcase
  end

  // LED output register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) led_q <= '0;
    else         led_q <= led_d;
  end

  assign bus.led_o = led_q;

endmodule

// File: tb/tb_sw_led_test.sv
// Scoreboard bench for sw_led_test: stimulus queues expected LED values tagged with the
// cycle they must appear; a negedge monitor pops and compares them.
module tb_sw_led_test;

`ifdef SW_LED_DEBOUNCE_EN
  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = 3 + DB;
`else
  localparam int unsigned DB  = 16;
  localparam int unsigned LAT = 3;
`endif

  typedef struct {
    int unsigned cyc;
    logic [6:0]  exp;
    string       name;
  } ent_t;

  typedef struct {
    logic [6:0] sw;
    logic [6:0] exp;
    string      name;
  } vec_t;

  logic        clk;
  logic        rstn;
  int unsigned cyc;
  int          n_checks;
  int          n_err;
  ent_t        q[$];

  sw_led_if bus_if ();

  sw_led_test #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: led_o=%h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each queued expectation on the negedge of its cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ent_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_checks++;
        n_err++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, bus_if.led_o, e.exp);
      end
    end
  end

  task automatic push(input int unsigned c, input logic [6:0] exp, input string name);
    ent_t e;
    e.cyc  = c;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  // Independent reference: loop parity and per-bit Gray.
  function automatic logic [6:0] model(input logic [6:0] v);
    logic [5:0] g;
    logic       p;
    p = 1'b0;
    for (int i = 0; i < 6; i++) p = p ^ v[i];
    for (int i = 0; i < 5; i++) g[i] = v[i] ^ v[i+1];
    g[5] = v[5];
    if (v[6]) return {1'b1, g};
    return {p, v[5:0]};
  endfunction

  // Drive a value just after an edge and expect it LAT edges later.
  task automatic apply(input logic [6:0] v, input logic [6:0] exp, input string name,
                       input int hold);
    @(posedge clk);
    #2;
    bus_if.sw_i = v;
    push(cyc + LAT, exp, name);
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations never reached", q.size());
      q.delete();
    end
  endtask

  // Hold reset with all switches up, then release and expect the Gray display of 0x3F.
  task automatic reset_release(input string tag);
    bus_if.sw_i = 7'h7F;
    repeat (3) begin
      @(posedge clk);
      #3;
      check({tag, "_in_reset"}, bus_if.led_o, 7'h00);
    end
    @(posedge clk);
    #2;
    rstn = 1'b1;
    push(cyc + LAT - 1, 7'h00, {tag, "_rel_early"});
    push(cyc + LAT,     7'h60, {tag, "_rel_out"});
    repeat (LAT + 1) @(posedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{7'h05, 7'h05, "m0_05"};
    vecs[1] = '{7'h07, 7'h47, "m0_07"};
    vecs[2] = '{7'h3F, 7'h3F, "m0_3f"};
    vecs[3] = '{7'h2A, 7'h6A, "m0_2a"};
    vecs[4] = '{7'h4A, 7'h4F, "m1_4a"};
    vecs[5] = '{7'h40, 7'h40, "m1_40"};
    vecs[6] = '{7'h55, 7'h5F, "m1_55"};
    vecs[7] = '{7'h7F, 7'h60, "m1_7f"};
    vecs[8] = '{7'h00, 7'h00, "m0_00"};

    n_checks    = 0;
    n_err       = 0;
    cyc         = 0;
    rstn        = 1'b0;
    bus_if.sw_i = 7'h7F;

    reset_release("por");

    foreach (vecs[i]) apply(vecs[i].sw, vecs[i].exp, vecs[i].name, LAT + 1);

    // Latency: 0x00 -> 0x01 must not show one edge early.
    apply(7'h00, 7'h00, "lat_base", LAT + 1);
    @(posedge clk);
    #2;
    bus_if.sw_i = 7'h01;
    push(cyc + LAT - 1, 7'h00, "lat_early");
    push(cyc + LAT,     7'h41, "lat_edge");
    repeat (LAT + 1) @(posedge clk);

`ifdef SW_LED_DEBOUNCE_EN
    // A 3-clock glitch on bit 0 must be filtered.
    apply(7'h00, 7'h00, "glitch_base", LAT + 1);
    @(posedge clk);
    #2;
    bus_if.sw_i = 7'h01;
    for (int k = 1; k <= int'(LAT) + 4; k++) push(cyc + k, 7'h00, "glitch");
    repeat (3) @(posedge clk);
    #2;
    bus_if.sw_i = 7'h00;
    repeat (LAT + 4) @(posedge clk);
`endif

    // Mode 0 sweep.
    for (int v = 0; v < 64; v++) begin
      logic [6:0] sv;
      sv = 7'(v);
      apply(sv, model(sv), "sweep", (LAT > 3) ? LAT + 1 : 4);
    end

    // Async reset mid-sweep, between edges.
    apply(7'h2A, 7'h6A, "pre_reset", LAT + 1);
    drain();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset", bus_if.led_o, 7'h00);
    reset_release("rst2");

    drain();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
